// File: rtl/bicubic_pixel_framer.sv
// rtl/bicubic_pixel_framer.sv - tags a raster pixel stream with x/y/frame markers for a bicubic core
//
// Accepts {R,G,B} pixels on s_valid/s_ready, stamps each with its column, row and
// sof/eol/eof flags at push time, and buffers them in a FIFO_DEPTH-entry FIFO
// presented on m_valid/m_ready. Once the last pixel of a frame is accepted, input
// is blocked until the FIFO drains, then frame_done pulses for one cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_valid, s_ready, s_data upstream pixel stream (24-bit {R,G,B})
//   m_valid, m_ready, m_data downstream pixel stream
//   m_x, m_y                 column / row of m_data
//   m_sof, m_eol, m_eof      first pixel of frame, last of row, last of frame
//   frame_done               one-cycle pulse when a frame has fully drained
//   stall_cnt                downstream stall cycles (BICUBIC_FRAMER_STALL_CNT_EN)
//
// Optional feature macro: BICUBIC_FRAMER_STALL_CNT_EN enables the stall counter;
// without it stall_cnt is tied to zero.

module bicubic_pixel_framer #(
    parameter int SRC_W      = 960,
    parameter int SRC_H      = 540,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [23:0] m_data,
    output logic [15:0] m_x,
    output logic [15:0] m_y,
    output logic        m_sof,
    output logic        m_eol,
    output logic        m_eof,
    output logic        frame_done,
    output logic [31:0] stall_cnt
);

    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam int              EW      = 24 + 16 + 16 + 3;
    localparam logic [15:0]     X_LAST  = 16'(SRC_W - 1);
    localparam logic [15:0]     Y_LAST  = 16'(SRC_H - 1);
    localparam logic [PW:0]     DEPTH_C = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0]   PTR_ONE = 1;
    localparam logic [PW:0]     CNT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [EW-1:0]   rd_entry;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic [15:0]     x;
    logic [15:0]     y;

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            col_last;
    logic            row_last;
    logic            last_px;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign s_ready  = (state != DRAIN) && !full;
    assign m_valid  = !empty;
    assign push     = s_valid && s_ready;
    assign pop      = m_valid && m_ready;
    assign col_last = (x == X_LAST);
    assign row_last = (y == Y_LAST);
    assign last_px  = col_last && row_last;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (push) state_nxt = last_px ? DRAIN : RUN;
            RUN:     if (push && last_px) state_nxt = DRAIN;
            DRAIN:   if (empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // frame_done is registered so it lines up with the first IDLE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= (state == DRAIN) && (state_nxt == IDLE);
        end
    end

    // Raster position of the next pixel to be accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (push) begin
            if (col_last) begin
                x <= '0;
                y <= row_last ? '0 : y + 16'd1;
            end else begin
                x <= x + 16'd1;
            end
        end
    end

    // Storage carries no reset; entries are only visible through m_valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_data, x, y, (x == '0) && (y == '0), col_last, last_px};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Gate the head entry so an empty FIFO presents all-zero data and tags
    assign rd_entry = mem[rd_ptr];
    assign {m_data, m_x, m_y, m_sof, m_eol, m_eof} = m_valid ? rd_entry : '0;

`ifdef BICUBIC_FRAMER_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((state == IDLE) && push) begin
            stall_q <= '0;
        end else if (m_valid && !m_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_bicubic_pixel_framer.sv
// tb/tb_bicubic_pixel_framer.sv - scoreboard bench for bicubic_pixel_framer
module tb_bicubic_pixel_framer;

    localparam int AW = 4;
    localparam int AH = 2;
    localparam int BW = 5;
    localparam int BH = 3;
`ifdef BICUBIC_FRAMER_STALL_CNT_EN
    localparam logic [63:0] STALL_EXP = 64'd10;
`else
    localparam logic [63:0] STALL_EXP = 64'd0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s_valid_a = 1'b0, s_ready_a, m_valid_a, m_ready_a = 1'b0;
    logic [23:0] s_data_a = '0, m_data_a;
    logic [15:0] m_x_a, m_y_a;
    logic        m_sof_a, m_eol_a, m_eof_a, frame_done_a;
    logic [31:0] stall_cnt_a;

    logic        s_valid_b = 1'b0, s_ready_b, m_valid_b, m_ready_b = 1'b0;
    logic [23:0] s_data_b = '0, m_data_b;
    logic [15:0] m_x_b, m_y_b;
    logic        m_sof_b, m_eol_b, m_eof_b, frame_done_b;
    logic [31:0] stall_cnt_b;

    bicubic_pixel_framer #(.SRC_W(AW), .SRC_H(AH), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a), .m_x(m_x_a), .m_y(m_y_a),
        .m_sof(m_sof_a), .m_eol(m_eol_a), .m_eof(m_eof_a), .frame_done(frame_done_a),
        .stall_cnt(stall_cnt_a)
    );

    bicubic_pixel_framer #(.SRC_W(BW), .SRC_H(BH), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_x(m_x_b), .m_y(m_y_b),
        .m_sof(m_sof_b), .m_eol(m_eol_b), .m_eof(m_eof_b), .frame_done(frame_done_b),
        .stall_cnt(stall_cnt_b)
    );

    int          n_pass = 0;
    int          n_total = 0;
    logic [58:0] q_a[$];
    logic [58:0] q_b[$];
    int          n_a = 0, n_b = 0;
    int          fd_a = 0, fd_b = 0;
    bit          fdp_a = 0, fdp_b = 0;
    bit          rnd_a = 0, rnd_b = 0;
    bit          fix_a = 0, fix_b = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: the n-th pixel of a frame sits at column n%w, row n/w
    function automatic logic [58:0] exp_tag(input logic [23:0] d, input int n, input int w, input int h);
        int px = n % w;
        int py = n / w;
        return {d, 16'(px), 16'(py), n == 0, px == w - 1, (px == w - 1) && (py == h - 1)};
    endfunction

    // m_ready is only ever changed 2 time units after a rising edge
    always @(posedge clk) begin
        #2;
        m_ready_a = rnd_a ? 1'($urandom_range(0, 1)) : fix_a;
        m_ready_b = rnd_b ? 1'($urandom_range(0, 1)) : fix_b;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done_a) begin
                fd_a++;
                check("a_frame_done_one_cycle", 64'(fdp_a), 64'd0);
            end
            fdp_a = frame_done_a;
            if (m_valid_a) begin
                check("a_output_expected", 64'(q_a.size() != 0), 64'd1);
                if (q_a.size() != 0) begin
                    check("a_output_tags", 64'({m_data_a, m_x_a, m_y_a, m_sof_a, m_eol_a, m_eof_a}), 64'(q_a[0]));
                    if (m_ready_a) void'(q_a.pop_front());
                end
            end
        end else begin
            fdp_a = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done_b) begin
                fd_b++;
                check("b_frame_done_one_cycle", 64'(fdp_b), 64'd0);
            end
            fdp_b = frame_done_b;
            if (m_valid_b) begin
                check("b_output_expected", 64'(q_b.size() != 0), 64'd1);
                if (q_b.size() != 0) begin
                    check("b_output_tags", 64'({m_data_b, m_x_b, m_y_b, m_sof_b, m_eol_b, m_eof_b}), 64'(q_b[0]));
                    if (m_ready_b) void'(q_b.pop_front());
                end
            end
        end else begin
            fdp_b = 0;
        end
    end

    task automatic send_a(input logic [23:0] d);
        bit ok = 0;
        @(posedge clk); #1;
        s_valid_a = 1'b1;
        s_data_a  = d;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (s_ready_a) begin
                ok = 1;
                q_a.push_back(exp_tag(d, n_a, AW, AH));
                n_a = (n_a + 1) % (AW * AH);
                break;
            end
            @(posedge clk); #1;
        end
        check("a_pixel_accepted", 64'(ok), 64'd1);
    endtask

    task automatic send_b(input logic [23:0] d);
        bit ok = 0;
        @(posedge clk); #1;
        s_valid_b = 1'b1;
        s_data_b  = d;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (s_ready_b) begin
                ok = 1;
                q_b.push_back(exp_tag(d, n_b, BW, BH));
                n_b = (n_b + 1) % (BW * BH);
                break;
            end
            @(posedge clk); #1;
        end
        check("b_pixel_accepted", 64'(ok), 64'd1);
    endtask

    task automatic idle_a();
        @(posedge clk); #1;
        s_valid_a = 1'b0;
    endtask

    task automatic wait_a(input int fd_target);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk); #1;
            if (q_a.size() == 0 && !m_valid_a && fd_a >= fd_target) break;
        end
        check("a_drained", 64'(q_a.size()), 64'd0);
        check("a_frame_done_count", 64'(fd_a), 64'(fd_target));
    endtask

    task automatic reset_all(input bit r);
        @(negedge clk);
        rst = 1'b1;
        s_valid_a = 1'b0;
        s_valid_b = 1'b0;
        rnd_a = 0; rnd_b = 0;
        fix_a = r; fix_b = r;
        q_a.delete(); q_b.delete();
        n_a = 0; n_b = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_a();
        check("rst_s_ready", 64'(s_ready_a), 64'd1);
        check("rst_m_valid", 64'(m_valid_a), 64'd0);
        check("rst_m_data", 64'(m_data_a), 64'd0);
        check("rst_m_xy", 64'({m_x_a, m_y_a}), 64'd0);
        check("rst_flags", 64'({m_sof_a, m_eol_a, m_eof_a}), 64'd0);
        check("rst_frame_done", 64'(frame_done_a), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt_a), 64'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

    initial begin : main
        int acc;
        int stalls;
        int fd0;

        repeat (3) @(negedge clk);
        check_reset_a();
        rst = 1'b0;

        // Back-to-back frame of 8 pixels with m_ready held high
        fix_a = 1;
        @(posedge clk); #3;
        for (int i = 1; i <= AW * AH; i++) begin
            send_a(24'(i));
            if (i >= 2) check("a_push_to_valid_latency", 64'(m_valid_a), 64'd1);
        end
        idle_a();
        wait_a(1);

        // m_ready low: only four pushes fit, head is held, stall counter runs
        reset_all(0);
        acc = 0;
        stalls = 0;
        for (int c = 0; c < 40 && stalls < 10; c++) begin
            @(posedge clk); #1;
            s_valid_a = 1'b1;
            s_data_a  = 24'(acc + 1);
            @(negedge clk);
            if (m_valid_a && !m_ready_a) stalls++;
            if (s_ready_a) begin
                q_a.push_back(exp_tag(s_data_a, n_a, AW, AH));
                n_a = (n_a + 1) % (AW * AH);
                acc++;
            end
        end
        check("full_push_count", 64'(acc), 64'd4);
        check("full_s_ready", 64'(s_ready_a), 64'd0);
        check("full_head_data", 64'(m_data_a), 64'h1);
        check("stall_window_reached", 64'(stalls), 64'd10);
        fix_a = 1;
        idle_a();
        @(negedge clk);
        check("stall_cnt_value", 64'(stall_cnt_a), STALL_EXP);
        wait_a(fd_a);

        // Next frame's pixel must wait until the current frame has drained
        reset_all(1);
        rnd_a = 1;
        for (int i = 1; i <= 6; i++) send_a(24'(i));
        rnd_a = 0;
        fix_a = 1;
        send_a(24'd7);
        send_a(24'd8);
        idle_a();
        fix_a = 0;
        repeat (4) begin
            @(negedge clk);
            check("drain_s_ready_low", 64'(s_ready_a), 64'd0);
        end
        fd0 = fd_a;
        fix_a = 1;
        send_a(24'hAA);
        #1;
        check("drain_done_before_next", 64'(fd_a), 64'(fd0 + 1));
        idle_a();
        wait_a(fd0 + 1);

        // Asynchronous reset mid-frame discards everything without frame_done
        reset_all(0);
        for (int i = 1; i <= 3; i++) send_a(24'(i));
        idle_a();
        fd0 = fd_a;
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_a();
        q_a.delete();
        n_a = 0;
        @(negedge clk);
        rst = 1'b0;
        fix_a = 1;
        send_a(24'h55);
        idle_a();
        wait_a(fd0);

        // Random traffic, three 5x3 frames
        rnd_b = 1;
        for (int i = 0; i < 3 * BW * BH; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                s_valid_b = 1'b0;
            end
            send_b(24'($urandom));
        end
        @(posedge clk); #1;
        s_valid_b = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk); #1;
            if (q_b.size() == 0 && !m_valid_b && fd_b >= 3) break;
        end
        repeat (5) @(negedge clk);
        check("b_drained", 64'(q_b.size()), 64'd0);
        check("b_frame_done_count", 64'(fd_b), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bicubic_pixel_framer.md
BICUBIC_PIXEL_FRAMER -- requirements
Module: bicubic_pixel_framer

Interface
REQ-001 The block SHALL have parameter SRC_W, default 960, meaning source image width in pixels (2..65535).
REQ-002 The block SHALL have parameter SRC_H, default 540, meaning source image height in rows (1..65535).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of two, 2..16).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning asynchronous, active-high reset.
REQ-006 The block SHALL have port s_valid, input, 1, meaning the upstream pixel is valid.
REQ-007 The block SHALL have port s_ready, output, 1, meaning the block accepts a pixel this cycle.
REQ-008 The block SHALL have port s_data, input, 24, meaning the upstream pixel as {R,G,B}, 8 bits each.
REQ-009 The block SHALL have port m_valid, output, 1, meaning the downstream entry is valid.
REQ-010 The block SHALL have port m_ready, input, 1, meaning the bicubic core accepts the entry.
REQ-011 The block SHALL have port m_data, output, 24, meaning the pixel passed through unchanged.
REQ-012 The block SHALL have port m_x, output, 16, meaning the column of m_data.
REQ-013 The block SHALL have port m_y, output, 16, meaning the row of m_data.
REQ-014 The block SHALL have ports m_sof, m_eol and m_eof, output, 1 each, meaning first pixel of the frame, last pixel of a row, and last pixel of the frame.
REQ-015 The block SHALL have port frame_done, output, 1, meaning a one-cycle pulse at the end of a frame.
REQ-016 The block SHALL have port stall_cnt, output, 32, meaning the count of downstream stall cycles.

Function
REQ-017 Push SHALL occur on s_valid&s_ready; pop SHALL occur on m_valid&m_ready.
REQ-018 The block SHALL store {data,x,y,sof,eol,eof} per entry, tagged at push time.
REQ-019 The FSM SHALL have states IDLE, RUN and DRAIN.
- IDLE->RUN on the first push.
- RUN->DRAIN on the push of pixel (SRC_W-1,SRC_H-1).
- DRAIN->IDLE when the FIFO is empty.
REQ-020 s_ready SHALL be !full in IDLE and RUN, and 0 in DRAIN, so no pixel of the next frame enters before the current frame drains.
REQ-021 The x counter SHALL increment on each push and wrap SRC_W-1->0; y SHALL increment on that wrap and wrap SRC_H-1->0 at end of frame.
REQ-022 sof SHALL be set iff x=0,y=0; eol SHALL be set iff x=SRC_W-1; eof SHALL be set iff eol and y=SRC_H-1; for SRC_H=1 every eol pixel SHALL also be eof.
REQ-023 m_valid SHALL equal !empty; push-to-m_valid latency SHALL be 1 cycle, with no combinational s->m path.
REQ-024 m_data and the tags SHALL hold stable while m_valid&!m_ready.
REQ-025 Simultaneous push and pop SHALL leave the occupancy unchanged; the read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 frame_done SHALL pulse for exactly one cycle, on the cycle the FSM enters IDLE from DRAIN.
REQ-027 When the FIFO is full, the block SHALL hold s_ready low and keep s_data out of the FIFO; the upstream SHALL hold the pixel.

Reset
REQ-028 Reset SHALL return all state to its initial values asynchronously.
- FSM to IDLE; FIFO empty; x=y=0.
- s_ready=1, m_valid=0, m_data=0, m_x=m_y=0.
- m_sof=m_eol=m_eof=0, frame_done=0, stall_cnt=0.
REQ-029 Reset asserted mid-frame SHALL discard the FIFO contents and the partial frame, and SHALL NOT pulse frame_done.

Configuration
REQ-030 With BICUBIC_FRAMER_STALL_CNT_EN defined, stall_cnt SHALL increment on every cycle with m_valid&!m_ready, saturate at 0xFFFFFFFF, and clear on IDLE->RUN.
REQ-031 Without BICUBIC_FRAMER_STALL_CNT_EN, stall_cnt SHALL be constant 0 and the counter logic SHALL NOT be instantiated.

Verification
REQ-032 SRC_W=4, SRC_H=2, m_ready=1, 8 back-to-back pixels 0x000001..0x000008 -> the outputs SHALL match all of the following:
- m_data sequence identical to the input;
- m_x 0,1,2,3,0,1,2,3 and m_y 0,0,0,0,1,1,1,1;
- sof on the first pixel, eol on the 4th and 8th, eof on the 8th;
- frame_done pulsing once.
REQ-033 m_ready=0 with 6 pixels offered -> exactly 4 pushes, s_ready=0 after the 4th, and m_data=0x000001 held throughout.
REQ-034 Push the 8th pixel with the FIFO non-empty and offer pixel 0x0000AA -> s_ready SHALL stay 0 until the FIFO is empty and frame_done pulses, after which 0xAA SHALL emerge with sof=1, x=0, y=0.
REQ-035 Random s_valid and m_ready, 3 frames of SRC_W=5, SRC_H=3 -> no loss, duplication or reorder, and exactly 3 frame_done pulses.
REQ-036 Assert rst after 3 pushes, then restart -> outputs SHALL be at reset values, and the next pushed pixel SHALL carry sof=1, x=0, y=0.
REQ-037 With BICUBIC_FRAMER_STALL_CNT_EN defined and m_ready=0 for 10 cycles while m_valid=1 -> stall_cnt=10; without the macro, stall_cnt SHALL stay 0.
